// File: rtl/onchip_mem_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_pkg
// Shared constants and types for the on-chip RAM stream reader.
//   DATA_W / ADDR_W / MEM_DEPTH / CNT_W : RAM geometry and count width
//   rd_state_e    : reader FSM states
//   stream_word_t : one buffered stream beat (data + last marker)
//   addr_step()   : next RAM word address; wraps at MEM_DEPTH only when
//                   ONCHIP_MEM_STREAM_READER_WRAP_EN is defined
// ---------------------------------------------------------------------------
package onchip_mem_pkg;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 4000;
  localparam int CNT_W     = 13;

  // Packed beat width: data bits plus the last flag.
  localparam int STREAM_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } stream_word_t;

  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a);
`ifdef ONCHIP_MEM_STREAM_READER_WRAP_EN
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
`else
    return a + ADDR_W'(1);
`endif
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// ---------------------------------------------------------------------------
// stream_sync_fifo
// Synchronous FIFO with occupancy count; head entry is visible on pop_data
// without a read strobe (first-word fall-through).
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : write strobe / data; accepted when not full, or when
//                     full and popped in the same cycle
//   pop, pop_data   : consume head entry / head entry
//   count           : current number of stored entries
// ---------------------------------------------------------------------------
module stream_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still takes a push when the head leaves this cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// onchip_mem_stream_reader
// Avalon-style read master for the 256-bit on-chip RAM (1-cycle read
// latency). A start command reads word_count consecutive words from
// base_addr and forwards them on a valid/ready stream. Reads are issued only
// when a FIFO slot is guaranteed for the returning word, so backpressure
// never drops data.
//
// Optional build macro: ONCHIP_MEM_STREAM_READER_WRAP_EN
//   defined   : addresses wrap MEM_DEPTH-1 -> 0; err only on
//               base_addr >= MEM_DEPTH or word_count > MEM_DEPTH
//   undefined : err when base_addr >= MEM_DEPTH or
//               base_addr + word_count > MEM_DEPTH
//
// Ports
//   clk, reset_n          : clock, synchronous active-low reset
//   start, base_addr,
//   word_count            : command strobe and run description
//   busy, done, err       : run active, completion pulse, reject pulse
//   mem_*                 : RAM read port (write tied off)
//   out_data, out_valid,
//   out_ready, out_last   : output stream
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; validates command
// ST_RUN   | issuing reads while FIFO credit is available
// ST_DRAIN | all reads issued; waiting for FIFO and read pipe to empty
// ---------------------------------------------------------------------------
module onchip_mem_stream_reader
  import onchip_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = FCW + 1;

  rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [FCW-1:0]     fifo_count;
  stream_word_t       push_word;
  stream_word_t       head_word;
  logic               pop;
  logic               issue;
  logic               can_issue;
  logic               drained;
  logic               range_bad;
  logic [CRW-1:0]     used_slots;
  logic [CRW-1:0]     slot_cap;

  stream_sync_fifo #(
    .WIDTH (STREAM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .count     (fifo_count)
  );

  always_comb begin
    push_word.data = mem_readdata;
    push_word.last = inflight_last_q;
  end

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head_word.data;
  assign out_last  = head_word.last;

  // Credit: slots not already owned by stored or in-flight words. A pop this
  // cycle frees its slot for this cycle's issue, which is what sustains one
  // read per clock under full throughput.
  always_comb begin
    used_slots = CRW'(fifo_count) + CRW'(inflight_q);
    slot_cap   = CRW'(FIFO_DEPTH) + CRW'(pop);
    can_issue  = (used_slots < slot_cap);
  end

  // Finishing looks one cycle ahead: if the last buffered word leaves now,
  // done lands in the cycle right after that handshake.
  assign drained = !inflight_q &&
                   ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop));

`ifdef ONCHIP_MEM_STREAM_READER_WRAP_EN
  always_comb begin
    range_bad = (base_addr >= ADDR_W'(MEM_DEPTH)) ||
                (word_count > CNT_W'(MEM_DEPTH));
  end
`else
  logic [CNT_W:0] range_end;

  always_comb begin
    range_end = (CNT_W+1)'(base_addr) + (CNT_W+1)'(word_count);
    range_bad = (base_addr >= ADDR_W'(MEM_DEPTH)) ||
                (range_end > (CNT_W+1)'(MEM_DEPTH));
  end
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    issue           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = base_addr;
            remaining_d = word_count;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (can_issue) begin
          issue       = 1'b1;
          addr_d      = addr_step(addr_q);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
module tb_onchip_mem_stream_reader;
  import onchip_mem_pkg::*;

  localparam int DEPTH_BUF = 2;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    word_count;
  logic                busy, done, err;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect, mem_write, mem_clken;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid, out_ready, out_last;

  onchip_mem_stream_reader #(.FIFO_DEPTH(DEPTH_BUF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  typedef struct {
    int addr;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   issues = 0, hs = 0, done_cnt = 0, done_cyc = 0;
  int   first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = 0;
  bit   done_busy, prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Distinct content per RAM address (odd multiplier is a bijection).
  function automatic logic [DATA_W-1:0] word_of(input int a);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < 8; k++) begin
      w[k*32 +: 32] = (32'(a) * 32'h9E3779B1 + 32'(k) * 32'h01000193) ^ 32'hA5A50000;
    end
    return w;
  endfunction

  function automatic bit model_err(input int base, input int cnt);
`ifdef ONCHIP_MEM_STREAM_READER_WRAP_EN
    return (base >= MEM_DEPTH) || (cnt > MEM_DEPTH);
`else
    return (base >= MEM_DEPTH) || (base + cnt > MEM_DEPTH);
`endif
  endfunction

  function automatic int model_addr(input int base, input int i);
`ifdef ONCHIP_MEM_STREAM_READER_WRAP_EN
    return (base + i) % MEM_DEPTH;
`else
    return base + i;
`endif
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: data for the issued address one cycle later, garbage otherwise.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= word_of(int'(mem_address));
    else                mem_readdata <= {8{$urandom()}};
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor and scoreboard.
  initial begin
    exp_t e;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (mem_chipselect) issues++;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          chk("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data", out_data, word_of(e.addr));
            chk("last", out_last, e.last);
          end
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs++;
        end
        chk("outstanding", (issues - hs) <= DEPTH_BUF, 1);
        if (done) begin
          done_cnt++;
          done_cyc  = cyc;
          done_busy = busy;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic run_cmd(input int base, input int cnt, input bit chk_lat, input bit poke);
    int iss0, dc0, st_cyc, n;
    bit e_err;
    exp_t e;
    e_err = model_err(base, cnt);
    iss0 = issues;
    dc0  = done_cnt;
    first_valid_cyc = -1;
    first_hs_cyc    = -1;
    if (!e_err) begin
      for (int i = 0; i < cnt; i++) begin
        e.addr = model_addr(base, i);
        e.last = (i == cnt - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    start = 1; base_addr = ADDR_W'(base); word_count = CNT_W'(cnt);
    st_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    if (e_err) begin
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_done", done, 0);
      @(negedge clk);
      chk("err_width", err, 0);
      repeat (3) @(negedge clk);
      chk("err_noread", issues - iss0, 0);
    end else if (cnt == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_err", err, 0);
      @(negedge clk);
      chk("zero_width", done, 0);
      repeat (3) @(negedge clk);
      chk("zero_noread", issues - iss0, 0);
    end else begin
      chk("run_busy", busy, 1);
      chk("run_err", err, 0);
      if (poke) begin
        repeat (2) @(posedge clk);
        #1;
        start = 1; base_addr = '0; word_count = CNT_W'(3);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("poke_err", err, 0);
        chk("poke_busy", busy, 1);
      end
      n = 0;
      while (done_cnt == dc0 && n < cnt * 8 + 100) begin
        @(posedge clk);
        n++;
      end
      chk("run_done_seen", done_cnt - dc0, 1);
      chk("run_drained", exp_q.size(), 0);
      chk("run_reads", issues - iss0, cnt);
      chk("done_busy", done_busy, 0);
      chk("done_lat", done_cyc - last_hs_cyc, 1);
      if (chk_lat) begin
        chk("first_valid_lat", first_valid_cyc - st_cyc, 2);
        chk("back_to_back", last_hs_cyc - first_hs_cyc, cnt - 1);
      end
      @(negedge clk);
      chk("done_width", done, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    int dc0, b, c;
    reset_n = 0; start = 0; base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_be", mem_byteenable, {(DATA_W/8){1'b1}});
    chk("rst_clken", mem_clken, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk); #1;
    reset_n = 1;

    rdy_mode = 0;
    run_cmd(0, 4, 1, 0);
    rdy_mode = 1;
    run_cmd(10, 8, 0, 0);

    rdy_mode = 0;
    fork
      run_cmd(50, 12, 0, 0);
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 3;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_cs", mem_chipselect, 0);
        chk("stall_valid", out_valid, 1);
        rdy_mode = 0;
      end
    join

    run_cmd(5, 0, 0, 0);
    rdy_mode = 1;
    run_cmd(200, 6, 0, 1);
    rdy_mode = 0;
    run_cmd(3998, 4, 0, 0);
    run_cmd(3996, 4, 1, 0);
    run_cmd(4000, 1, 0, 0);
    run_cmd(3999, 1, 0, 0);

    // Reset in the middle of a stalled run.
    rdy_mode = 3;
    @(posedge clk); #1;
    start = 1; base_addr = ADDR_W'(300); word_count = CNT_W'(10);
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(negedge clk);
    chk("rst_pre_valid", out_valid, 1);
    chk("rst_pre_buffered", issues - hs, 2);
    dc0 = done_cnt;
    @(posedge clk); #1;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    issues = hs;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cs", mem_chipselect, 0);
    repeat (5) @(posedge clk);
    chk("rst_mid_nodone", done_cnt - dc0, 0);
    rdy_mode = 0;
    run_cmd(7, 5, 1, 0);

    for (int t = 0; t < 16; t++) begin
      b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(3985, 4005));
      case ($urandom_range(0, 7))
        0:       c = $urandom_range(0, 2);
        1:       c = $urandom_range(4001, 8191);
        default: c = $urandom_range(1, 24);
      endcase
      rdy_mode = $urandom_range(0, 2);
      run_cmd(b, c, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
